// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: MD_op one-hot bit indices,
// FSM states and a small operand helper.
package md_unit_pkg;

    localparam int MD_W   = 32;
    localparam int MD_OPW = 6;

    // Bit positions within the one-hot md_op vector
    localparam int MD_mult  = 0;
    localparam int MD_multu = 1;
    localparam int MD_div   = 2;
    localparam int MD_divu  = 3;
    localparam int MD_mthi  = 4;
    localparam int MD_mtlo  = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } md_state_t;

    function automatic logic [MD_W-1:0] abs32(input logic [MD_W-1:0] v, input logic sgn);
        return (sgn && v[MD_W-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// EXE-side request/response bundle of the multiply/divide unit.
interface md_unit_if;
    import md_unit_pkg::*;

    logic              md_valid;
    logic [MD_OPW-1:0] md_op;
    logic [MD_W-1:0]   md_src1;
    logic [MD_W-1:0]   md_src2;
    logic              md_flush;
    logic              md_rdsel;
    logic [MD_W-1:0]   MD_data;
    logic              md_busy;
    logic              md_done;

    modport master (
        output md_valid, md_op, md_src1, md_src2, md_flush, md_rdsel,
        input  MD_data, md_busy, md_done
    );

    modport slave (
        input  md_valid, md_op, md_src1, md_src2, md_flush, md_rdsel,
        output MD_data, md_busy, md_done
    );
endinterface

// File: rtl/md_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, 32 cycles.
// quotient/remainder show the result of the current step and are final while last=1.
module md_divider
    import md_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [MD_W-1:0] dividend,
    input  logic [MD_W-1:0] divisor,
    output logic [MD_W-1:0] quotient,
    output logic [MD_W-1:0] remainder,
    output logic            last
);

    logic            running;
    logic [5:0]      cnt;
    logic [MD_W-1:0] q_r;
    logic [MD_W-1:0] r_r;
    logic [MD_W-1:0] d_r;
    logic [MD_W:0]   r_shift;
    logic [MD_W-1:0] r_diff;
    logic            ge;

    // q_r doubles as the dividend shift register; its MSB feeds the partial remainder
    always_comb begin
        r_shift   = {r_r, q_r[MD_W-1]};
        ge        = (r_shift >= {1'b0, d_r});
        r_diff    = r_shift[MD_W-1:0] - d_r;
        quotient  = {q_r[MD_W-2:0], ge};
        remainder = ge ? r_diff : r_shift[MD_W-1:0];
        last      = running && (cnt == 6'd31);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
            q_r     <= '0;
            r_r     <= '0;
            d_r     <= '0;
        end else if (flush) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            q_r     <= dividend;
            r_r     <= '0;
            d_r     <= divisor;
        end else if (running) begin
            q_r <= quotient;
            r_r <= remainder;
            if (cnt == 6'd31) begin
                running <= 1'b0;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO: 1-cycle multiply, 32-cycle
// iterative divide, MTHI/MTLO writes, flush cancels in-flight ops.
module md_unit
    import md_unit_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave md
);

    md_state_t       state;
    logic [MD_W-1:0] hi;
    logic [MD_W-1:0] lo;
    logic [MD_W-1:0] mul_a;
    logic [MD_W-1:0] mul_b;
    logic            mul_signed;
    logic            q_neg;
    logic            r_neg;
    logic            div_zero;
    logic [MD_W-1:0] div_src1;

    logic            op_onehot;
    logic            accept;
    logic            is_mul;
    logic            is_div;
    logic            div_signed;
    logic            div_start;
    logic [2*MD_W-1:0] ext_a;
    logic [2*MD_W-1:0] ext_b;
    logic [2*MD_W-1:0] prod;
    logic [MD_W-1:0] div_q;
    logic [MD_W-1:0] div_r;
    logic            div_last;
    logic [MD_W-1:0] lo_div;
    logic [MD_W-1:0] hi_div;

    always_comb begin
        op_onehot  = (md.md_op != '0) && ((md.md_op & (md.md_op - 6'd1)) == '0);
        accept     = md.md_valid && !md.md_flush && (state == ST_IDLE) && op_onehot;
        is_mul     = md.md_op[MD_mult] | md.md_op[MD_multu];
        is_div     = md.md_op[MD_div]  | md.md_op[MD_divu];
        div_signed = md.md_op[MD_div];
        div_start  = accept && is_div;

        ext_a = {{MD_W{mul_signed & mul_a[MD_W-1]}}, mul_a};
        ext_b = {{MD_W{mul_signed & mul_b[MD_W-1]}}, mul_b};
        prod  = ext_a * ext_b;

        // Divide-by-zero bypasses the sign fix-up and returns the raw dividend in HI
        if (div_zero) begin
            lo_div = '1;
            hi_div = div_src1;
        end else begin
            lo_div = q_neg ? (~div_q + 32'd1) : div_q;
            hi_div = r_neg ? (~div_r + 32'd1) : div_r;
        end
    end

    md_divider u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .flush     (md.md_flush),
        .dividend  (abs32(md.md_src1, div_signed)),
        .divisor   (abs32(md.md_src2, div_signed)),
        .quotient  (div_q),
        .remainder (div_r),
        .last      (div_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            hi         <= '0;
            lo         <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            div_zero   <= 1'b0;
            div_src1   <= '0;
        end else if (md.md_flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            mul_a      <= md.md_src1;
                            mul_b      <= md.md_src2;
                            mul_signed <= md.md_op[MD_mult];
                            state      <= ST_MUL;
                        end else if (is_div) begin
                            q_neg    <= div_signed & (md.md_src1[MD_W-1] ^ md.md_src2[MD_W-1]);
                            r_neg    <= div_signed & md.md_src1[MD_W-1];
                            div_zero <= (md.md_src2 == '0);
                            div_src1 <= md.md_src1;
                            state    <= ST_DIV;
                        end else if (md.md_op[MD_mthi]) begin
                            hi <= md.md_src1;
                        end else if (md.md_op[MD_mtlo]) begin
                            lo <= md.md_src1;
                        end
                    end
                end
                ST_MUL: begin
                    hi    <= prod[2*MD_W-1:MD_W];
                    lo    <= prod[MD_W-1:0];
                    state <= ST_IDLE;
                end
                ST_DIV: begin
                    if (div_last) begin
                        hi    <= hi_div;
                        lo    <= lo_div;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign md.MD_data = md.md_rdsel ? hi : lo;
    assign md.md_busy = (state != ST_IDLE);
    assign md.md_done = !md.md_flush && ((state == ST_MUL) || ((state == ST_DIV) && div_last));

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit against an arithmetic HI/LO reference model.
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_if bus ();

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: HI/LO after an op, from plain integer arithmetic
    task automatic model(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] up;
        case (op)
            MD_mult: begin
                sa = $signed(a); sb = $signed(b); p = sa * sb;
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            MD_multu: begin
                up = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32]; m_lo = up[31:0];
            end
            MD_div, MD_divu: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else if (op == MD_div) begin
                    sa = $signed(a); sb = $signed(b); q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            MD_mthi: m_hi = a;
            MD_mtlo: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic read_check(input string tag);
        bus.md_rdsel = 1'b1;
        #1 check_val({tag, "_hi"}, bus.MD_data, m_hi);
        bus.md_rdsel = 1'b0;
        #1 check_val({tag, "_lo"}, bus.MD_data, m_lo);
    endtask

    // Issue one op, measure busy length and done pulses, then compare HI/LO
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input string tag);
        int exp_len;
        int cycles;
        int dones;
        logic done_last;
        logic [31:0] old_lo;
        exp_len = (op == MD_mult || op == MD_multu) ? 1 : (op == MD_div || op == MD_divu) ? 32 : 0;
        old_lo = m_lo;
        @(negedge clk);
        bus.md_valid = 1'b1;
        bus.md_op    = 6'b1 << op;
        bus.md_src1  = a;
        bus.md_src2  = b;
        @(negedge clk);
        bus.md_valid = 1'b0;
        bus.md_op    = '0;
        cycles = 0; dones = 0; done_last = 1'b0;
        while (bus.md_busy && cycles < 100) begin
            bus.md_rdsel = 1'b0;
            #1;
            if (cycles == 0) check_val({tag, "_lo_during_busy"}, bus.MD_data, old_lo);
            if (bus.md_done) dones++;
            done_last = bus.md_done;
            cycles++;
            @(negedge clk);
        end
        check_val({tag, "_busy_len"}, cycles, exp_len);
        check_val({tag, "_done_cnt"}, dones, (exp_len > 0) ? 1 : 0);
        if (exp_len > 0) check_val({tag, "_done_last"}, {31'd0, done_last}, 32'd1);
        model(op, a, b);
        read_check(tag);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cycles;
        reset = 1'b1;
        bus.md_valid = 1'b0; bus.md_op = '0; bus.md_src1 = '0; bus.md_src2 = '0;
        bus.md_flush = 1'b0; bus.md_rdsel = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_busy", {31'd0, bus.md_busy}, 32'd0);
        check_val("reset_done", {31'd0, bus.md_done}, 32'd0);
        read_check("reset");
        reset = 1'b0;

        run_op(MD_mthi, 32'h1234_5678, 32'd0, "mthi");
        run_op(MD_mtlo, 32'h9ABC_DEF0, 32'd0, "mtlo");
        run_op(MD_mult,  32'hFFFF_FFFD, 32'd7, "mult_m3x7");
        bus.md_rdsel = 1'b0;
        #1 check_val("mult_m3x7_lit_lo", bus.MD_data, 32'hFFFF_FFEB);
        run_op(MD_multu, 32'hFFFF_FFFF, 32'd2, "multu_max_x2");
        run_op(MD_div,   32'hFFFF_FFF9, 32'd2, "div_m7_2");
        bus.md_rdsel = 1'b1;
        #1 check_val("div_m7_2_lit_hi", bus.MD_data, 32'hFFFF_FFFF);
        run_op(MD_divu,  32'd100, 32'd7, "divu_100_7");
        run_op(MD_div,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(MD_divu,  32'd5, 32'd0, "divu_by0");
        run_op(MD_div,   32'hFFFF_FFF9, 32'd0, "div_neg_by0");

        // Invalid op encodings are no-ops
        @(negedge clk);
        bus.md_valid = 1'b1; bus.md_op = '0; bus.md_src1 = 32'hDEAD_BEEF;
        @(negedge clk);
        check_val("op_zero_busy", {31'd0, bus.md_busy}, 32'd0);
        bus.md_op = 6'b000011;
        @(negedge clk);
        bus.md_valid = 1'b0; bus.md_op = '0;
        check_val("op_multihot_busy", {31'd0, bus.md_busy}, 32'd0);
        read_check("invalid_op");

        // Flush in busy cycle 10 of a divide
        run_op(MD_mthi, 32'h11, 32'd0, "pre_flush_hi");
        run_op(MD_mtlo, 32'h11, 32'd0, "pre_flush_lo");
        @(negedge clk);
        bus.md_valid = 1'b1; bus.md_op = 6'b1 << MD_div; bus.md_src1 = 32'd100; bus.md_src2 = 32'd7;
        @(negedge clk);
        bus.md_valid = 1'b0; bus.md_op = '0;
        repeat (9) @(negedge clk);
        check_val("flush_busy_before", {31'd0, bus.md_busy}, 32'd1);
        bus.md_flush = 1'b1;
        #1 check_val("flush_done_forced", {31'd0, bus.md_done}, 32'd0);
        @(negedge clk);
        bus.md_flush = 1'b0;
        check_val("flush_busy_after", {31'd0, bus.md_busy}, 32'd0);
        check_val("flush_done_after", {31'd0, bus.md_done}, 32'd0);
        read_check("flush");

        // Request in the same cycle as flush is dropped
        bus.md_valid = 1'b1; bus.md_op = 6'b1 << MD_mtlo; bus.md_src1 = 32'h99; bus.md_flush = 1'b1;
        @(negedge clk);
        bus.md_op = 6'b1 << MD_div; bus.md_src2 = 32'd3;
        @(negedge clk);
        bus.md_valid = 1'b0; bus.md_op = '0; bus.md_flush = 1'b0;
        check_val("flush_valid_busy", {31'd0, bus.md_busy}, 32'd0);
        read_check("flush_valid");

        // MTLO held through a divide: ignored while busy, accepted when idle
        bus.md_valid = 1'b1; bus.md_op = 6'b1 << MD_divu; bus.md_src1 = 32'd100; bus.md_src2 = 32'd7;
        @(negedge clk);
        bus.md_op = 6'b1 << MD_mtlo; bus.md_src1 = 32'h77;
        cycles = 0;
        while (bus.md_busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        check_val("held_busy_len", cycles, 32);
        model(MD_divu, 32'd100, 32'd7);
        read_check("held_div");
        @(negedge clk);
        bus.md_valid = 1'b0; bus.md_op = '0;
        model(MD_mtlo, 32'h77, 32'd0);
        read_check("held_mtlo");

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 5);
            run_op(op, pick(), pick(), $sformatf("rnd%0d_op%0d", i, op));
        end

        // Reset mid-divide wins over flush and a pending request
        @(negedge clk);
        bus.md_valid = 1'b1; bus.md_op = 6'b1 << MD_div; bus.md_src1 = 32'd1000; bus.md_src2 = 32'd3;
        @(negedge clk);
        bus.md_valid = 1'b1; bus.md_op = 6'b1 << MD_mthi; bus.md_src1 = 32'h55;
        repeat (4) @(negedge clk);
        reset = 1'b1; bus.md_flush = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.md_flush = 1'b0; bus.md_valid = 1'b0; bus.md_op = '0;
        check_val("midreset_busy", {31'd0, bus.md_busy}, 32'd0);
        m_hi = '0; m_lo = '0;
        read_check("midreset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
